// File: rtl/rename_map_pkg.sv
// Shared widths, map-entry and renamed-slot payload types for the rename stage.
package rename_map_pkg;

    localparam int unsigned ARCH_NUM     = 32;
    localparam int unsigned ARCH_SEL     = 5;
    localparam int unsigned PREG_SEL     = 6;
    localparam int unsigned MAP_RD_PORTS = 6;

    typedef struct packed {
        logic                vld;
        logic [PREG_SEL-1:0] tag;
    } map_entry_t;

    typedef struct packed {
        logic                valid;
        map_entry_t          rs1;
        map_entry_t          rs2;
        logic [PREG_SEL-1:0] rd;
        logic                wr;
        map_entry_t          old;
    } rn_slot_t;

    // Arch 0 reads as "no tag"; an older same-group writer overrides the map.
    function automatic map_entry_t src_lookup(
        input logic [ARCH_SEL-1:0] arch,
        input map_entry_t          map_rd,
        input logic                byp_en,
        input logic [ARCH_SEL-1:0] byp_rd,
        input logic [PREG_SEL-1:0] byp_tag
    );
        map_entry_t r;
        r = map_rd;
        if (arch == '0) begin
            r = '0;
        end else if (byp_en && (arch == byp_rd)) begin
            r.vld = 1'b1;
            r.tag = byp_tag;
        end
        return r;
    endfunction

endpackage

// File: rtl/rename_map_map_table.sv
// Arch-to-physical map: async read ports, two write ports (port 2 wins) and a
// bulk load that is applied underneath the same-cycle writes.
module rename_map_map_table
    import rename_map_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [MAP_RD_PORTS-1:0][ARCH_SEL-1:0]     i_raddr,
    output map_entry_t [MAP_RD_PORTS-1:0]             o_rdata,
    input  logic                                      i_we_1,
    input  logic [ARCH_SEL-1:0]                       i_wa_1,
    input  logic [PREG_SEL-1:0]                       i_wt_1,
    input  logic                                      i_we_2,
    input  logic [ARCH_SEL-1:0]                       i_wa_2,
    input  logic [PREG_SEL-1:0]                       i_wt_2,
    input  logic                                      i_load,
    input  map_entry_t [ARCH_NUM-1:0]                 i_load_map,
    output map_entry_t [ARCH_NUM-1:0]                 o_map
);

    map_entry_t [ARCH_NUM-1:0] r_map;
    map_entry_t [ARCH_NUM-1:0] w_map_nx;

    // r0 is never written so it always reads invalid.
    always_comb begin
        w_map_nx = i_load ? i_load_map : r_map;
        if (i_we_1 && (i_wa_1 != '0)) begin
            w_map_nx[i_wa_1].vld = 1'b1;
            w_map_nx[i_wa_1].tag = i_wt_1;
        end
        if (i_we_2 && (i_wa_2 != '0)) begin
            w_map_nx[i_wa_2].vld = 1'b1;
            w_map_nx[i_wa_2].tag = i_wt_2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_map <= '0;
        end else begin
            r_map <= w_map_nx;
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < int'(MAP_RD_PORTS); i++) begin
            o_rdata[i] = r_map[i_raddr[i]];
        end
    end

    assign o_map = r_map;

endmodule

// File: rtl/rename_map.sv
// 2-wide rename stage: maps sources through the speculative map, attaches freelist
// tags to destinations, bypasses slot 1 -> slot 2, and restores from the committed map on prmiss.
module rename_map
    import rename_map_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                prmiss,
    input  logic                stall_DP,
    input  logic                dc_valid_1,
    input  logic                dc_valid_2,
    input  logic [ARCH_SEL-1:0] dc_rs1_1,
    input  logic [ARCH_SEL-1:0] dc_rs1_2,
    input  logic [ARCH_SEL-1:0] dc_rs2_1,
    input  logic [ARCH_SEL-1:0] dc_rs2_2,
    input  logic [ARCH_SEL-1:0] dc_rd_1,
    input  logic [ARCH_SEL-1:0] dc_rd_2,
    input  logic                dc_wr_1,
    input  logic                dc_wr_2,
    input  logic [PREG_SEL-1:0] alloc_1,
    input  logic [PREG_SEL-1:0] alloc_2,
    input  logic                alloc_valid_1,
    input  logic                alloc_valid_2,
    input  logic                allocatable,
    output logic                alloc_inv_1,
    output logic                alloc_inv_2,
    output logic                stall_rn,
    input  logic                com_valid_1,
    input  logic                com_valid_2,
    input  logic [ARCH_SEL-1:0] com_rd_1,
    input  logic [ARCH_SEL-1:0] com_rd_2,
    input  logic [PREG_SEL-1:0] com_preg_1,
    input  logic [PREG_SEL-1:0] com_preg_2,
    output logic                rn_valid_1,
    output logic                rn_valid_2,
    output logic [PREG_SEL-1:0] rn_rs1_1,
    output logic [PREG_SEL-1:0] rn_rs1_2,
    output logic                rn_rs1v_1,
    output logic                rn_rs1v_2,
    output logic [PREG_SEL-1:0] rn_rs2_1,
    output logic [PREG_SEL-1:0] rn_rs2_2,
    output logic                rn_rs2v_1,
    output logic                rn_rs2v_2,
    output logic [PREG_SEL-1:0] rn_rd_1,
    output logic [PREG_SEL-1:0] rn_rd_2,
    output logic                rn_wr_1,
    output logic                rn_wr_2,
    output logic [PREG_SEL-1:0] rn_old_1,
    output logic [PREG_SEL-1:0] rn_old_2,
    output logic                rn_oldv_1,
    output logic                rn_oldv_2
);

    logic w_advance;
    logic w_wr_1;
    logic w_wr_2;
    logic w_take_1;
    logic w_take_2;

    logic [MAP_RD_PORTS-1:0][ARCH_SEL-1:0] w_sm_raddr;
    map_entry_t [MAP_RD_PORTS-1:0]         w_sm_rdata;
    map_entry_t [ARCH_NUM-1:0]             w_cm_map;
    map_entry_t [ARCH_NUM-1:0]             w_unused_sm_map;
    map_entry_t [MAP_RD_PORTS-1:0]         w_unused_cm_rdata;

    logic                w_sm_we_1;
    logic                w_sm_we_2;
    logic [ARCH_SEL-1:0] w_sm_wa_1;
    logic [ARCH_SEL-1:0] w_sm_wa_2;
    logic [PREG_SEL-1:0] w_sm_wt_1;
    logic [PREG_SEL-1:0] w_sm_wt_2;

    rn_slot_t w_rn_1;
    rn_slot_t w_rn_2;
    rn_slot_t r_rn_1;
    rn_slot_t r_rn_2;

    assign w_advance   = ~prmiss & ~stall_DP & allocatable;
    assign stall_rn    = ~w_advance;
    assign w_wr_1      = dc_valid_1 & dc_wr_1 & (dc_rd_1 != '0);
    assign w_wr_2      = dc_valid_2 & dc_wr_2 & (dc_rd_2 != '0);
    assign alloc_inv_1 = ~w_wr_1;
    assign alloc_inv_2 = ~w_wr_2;
    // A granted slot only consumes its tag when the freelist marks it valid.
    assign w_take_1    = w_wr_1 & alloc_valid_1;
    assign w_take_2    = w_wr_2 & alloc_valid_2;

    assign w_sm_raddr = {dc_rd_2, dc_rd_1, dc_rs2_2, dc_rs1_2, dc_rs2_1, dc_rs1_1};

    always_comb begin
        w_rn_1       = '0;
        w_rn_1.valid = dc_valid_1;
        w_rn_1.rs1   = src_lookup(dc_rs1_1, w_sm_rdata[0], 1'b0, '0, '0);
        w_rn_1.rs2   = src_lookup(dc_rs2_1, w_sm_rdata[1], 1'b0, '0, '0);
        w_rn_1.wr    = w_take_1;
        if (w_take_1) begin
            w_rn_1.rd  = alloc_1;
            w_rn_1.old = w_sm_rdata[4];
        end

        w_rn_2       = '0;
        w_rn_2.valid = dc_valid_2;
        w_rn_2.rs1   = src_lookup(dc_rs1_2, w_sm_rdata[2], w_take_1, dc_rd_1, alloc_1);
        w_rn_2.rs2   = src_lookup(dc_rs2_2, w_sm_rdata[3], w_take_1, dc_rd_1, alloc_1);
        w_rn_2.wr    = w_take_2;
        if (w_take_2) begin
            w_rn_2.rd  = alloc_2;
            w_rn_2.old = src_lookup(dc_rd_2, w_sm_rdata[5], w_take_1, dc_rd_1, alloc_1);
        end
    end

    // Speculative map writes: commit ports during restore, decode pair on advance.
    always_comb begin
        w_sm_we_1 = 1'b0;
        w_sm_we_2 = 1'b0;
        w_sm_wa_1 = dc_rd_1;
        w_sm_wa_2 = dc_rd_2;
        w_sm_wt_1 = alloc_1;
        w_sm_wt_2 = alloc_2;
        if (prmiss) begin
            w_sm_we_1 = com_valid_1;
            w_sm_we_2 = com_valid_2;
            w_sm_wa_1 = com_rd_1;
            w_sm_wa_2 = com_rd_2;
            w_sm_wt_1 = com_preg_1;
            w_sm_wt_2 = com_preg_2;
        end else if (w_advance) begin
            w_sm_we_1 = w_take_1;
            w_sm_we_2 = w_take_2;
        end
    end

    rename_map_map_table u_spec_map (
        .clk        (clk),
        .reset      (reset),
        .i_raddr    (w_sm_raddr),
        .o_rdata    (w_sm_rdata),
        .i_we_1     (w_sm_we_1),
        .i_wa_1     (w_sm_wa_1),
        .i_wt_1     (w_sm_wt_1),
        .i_we_2     (w_sm_we_2),
        .i_wa_2     (w_sm_wa_2),
        .i_wt_2     (w_sm_wt_2),
        .i_load     (prmiss),
        .i_load_map (w_cm_map),
        .o_map      (w_unused_sm_map)
    );

    rename_map_map_table u_com_map (
        .clk        (clk),
        .reset      (reset),
        .i_raddr    ('0),
        .o_rdata    (w_unused_cm_rdata),
        .i_we_1     (com_valid_1),
        .i_wa_1     (com_rd_1),
        .i_wt_1     (com_preg_1),
        .i_we_2     (com_valid_2),
        .i_wa_2     (com_rd_2),
        .i_wt_2     (com_preg_2),
        .i_load     (1'b0),
        .i_load_map ('0),
        .o_map      (w_cm_map)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rn_1 <= '0;
            r_rn_2 <= '0;
        end else if (prmiss) begin
            r_rn_1 <= '0;
            r_rn_2 <= '0;
        end else if (w_advance) begin
            r_rn_1 <= w_rn_1;
            r_rn_2 <= w_rn_2;
        end
    end

    assign rn_valid_1 = r_rn_1.valid;
    assign rn_rs1_1   = r_rn_1.rs1.tag;
    assign rn_rs1v_1  = r_rn_1.rs1.vld;
    assign rn_rs2_1   = r_rn_1.rs2.tag;
    assign rn_rs2v_1  = r_rn_1.rs2.vld;
    assign rn_rd_1    = r_rn_1.rd;
    assign rn_wr_1    = r_rn_1.wr;
    assign rn_old_1   = r_rn_1.old.tag;
    assign rn_oldv_1  = r_rn_1.old.vld;

    assign rn_valid_2 = r_rn_2.valid;
    assign rn_rs1_2   = r_rn_2.rs1.tag;
    assign rn_rs1v_2  = r_rn_2.rs1.vld;
    assign rn_rs2_2   = r_rn_2.rs2.tag;
    assign rn_rs2v_2  = r_rn_2.rs2.vld;
    assign rn_rd_2    = r_rn_2.rd;
    assign rn_wr_2    = r_rn_2.wr;
    assign rn_old_2   = r_rn_2.old.tag;
    assign rn_oldv_2  = r_rn_2.old.vld;

endmodule

// File: tb/tb_rename_map.sv
// Bench for rename_map: directed scenarios plus random traffic against an array-based map model.
module tb_rename_map;

    logic       clk = 1'b0;
    logic       reset;
    logic       prmiss, stall_DP, allocatable;
    logic       v   [1:2];
    logic [4:0] a1  [1:2];
    logic [4:0] a2  [1:2];
    logic [4:0] rd  [1:2];
    logic       wr  [1:2];
    logic [5:0] al  [1:2];
    logic       alv [1:2];
    logic       cv  [1:2];
    logic [4:0] crd [1:2];
    logic [5:0] cp  [1:2];

    logic       o_inv  [1:2];
    logic       stall_rn;
    logic       o_v    [1:2];
    logic [5:0] o_rs1  [1:2];
    logic       o_rs1v [1:2];
    logic [5:0] o_rs2  [1:2];
    logic       o_rs2v [1:2];
    logic [5:0] o_rd   [1:2];
    logic       o_wr   [1:2];
    logic [5:0] o_old  [1:2];
    logic       o_oldv [1:2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: two maps and the expected registered pair.
    logic       m_sv [0:31];
    logic [5:0] m_st [0:31];
    logic       m_cv [0:31];
    logic [5:0] m_ct [0:31];
    logic       e_v    [1:2];
    logic [5:0] e_rs1  [1:2];
    logic       e_rs1v [1:2];
    logic [5:0] e_rs2  [1:2];
    logic       e_rs2v [1:2];
    logic [5:0] e_rd   [1:2];
    logic       e_wr   [1:2];
    logic [5:0] e_old  [1:2];
    logic       e_oldv [1:2];

    always #5 clk = ~clk;

    rename_map dut (
        .clk(clk), .reset(reset), .prmiss(prmiss), .stall_DP(stall_DP),
        .dc_valid_1(v[1]), .dc_valid_2(v[2]),
        .dc_rs1_1(a1[1]), .dc_rs1_2(a1[2]), .dc_rs2_1(a2[1]), .dc_rs2_2(a2[2]),
        .dc_rd_1(rd[1]), .dc_rd_2(rd[2]), .dc_wr_1(wr[1]), .dc_wr_2(wr[2]),
        .alloc_1(al[1]), .alloc_2(al[2]), .alloc_valid_1(alv[1]), .alloc_valid_2(alv[2]),
        .allocatable(allocatable), .alloc_inv_1(o_inv[1]), .alloc_inv_2(o_inv[2]),
        .stall_rn(stall_rn),
        .com_valid_1(cv[1]), .com_valid_2(cv[2]), .com_rd_1(crd[1]), .com_rd_2(crd[2]),
        .com_preg_1(cp[1]), .com_preg_2(cp[2]),
        .rn_valid_1(o_v[1]), .rn_valid_2(o_v[2]),
        .rn_rs1_1(o_rs1[1]), .rn_rs1_2(o_rs1[2]), .rn_rs1v_1(o_rs1v[1]), .rn_rs1v_2(o_rs1v[2]),
        .rn_rs2_1(o_rs2[1]), .rn_rs2_2(o_rs2[2]), .rn_rs2v_1(o_rs2v[1]), .rn_rs2v_2(o_rs2v[2]),
        .rn_rd_1(o_rd[1]), .rn_rd_2(o_rd[2]), .rn_wr_1(o_wr[1]), .rn_wr_2(o_wr[2]),
        .rn_old_1(o_old[1]), .rn_old_2(o_old[2]), .rn_oldv_1(o_oldv[1]), .rn_oldv_2(o_oldv[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_sv[i] = 1'b0; m_st[i] = '0; m_cv[i] = 1'b0; m_ct[i] = '0;
        end
        for (int s = 1; s <= 2; s++) begin
            e_v[s] = 0; e_rs1[s] = 0; e_rs1v[s] = 0; e_rs2[s] = 0; e_rs2v[s] = 0;
            e_rd[s] = 0; e_wr[s] = 0; e_old[s] = 0; e_oldv[s] = 0;
        end
    endtask

    // Source lookup as the rules state it: r0 -> none, older writer in group -> its tag, else map.
    task automatic lookup(input logic [4:0] arch, input logic byp, input logic [4:0] brd,
                          input logic [5:0] btag, output logic [5:0] tag, output logic vld);
        if (arch == 0) begin
            tag = 0; vld = 0;
        end else if (byp && arch == brd) begin
            tag = btag; vld = 1;
        end else begin
            tag = m_st[arch]; vld = m_sv[arch];
        end
    endtask

    task automatic model_edge();
        logic w [1:2];
        for (int s = 1; s <= 2; s++)
            if (cv[s] && crd[s] != 0) begin
                m_cv[crd[s]] = 1'b1; m_ct[crd[s]] = cp[s];
            end
        if (prmiss) begin
            for (int i = 0; i < 32; i++) begin
                m_sv[i] = m_cv[i]; m_st[i] = m_ct[i];
            end
            e_v[1] = 0; e_v[2] = 0;
        end else if (!stall_DP && allocatable) begin
            for (int s = 1; s <= 2; s++) w[s] = v[s] && wr[s] && rd[s] != 0;
            for (int s = 1; s <= 2; s++) begin
                logic bp;
                bp = (s == 2) && w[1];
                e_v[s]  = v[s];
                e_wr[s] = w[s];
                e_rd[s] = w[s] ? al[s] : 6'd0;
                lookup(a1[s], bp, rd[1], al[1], e_rs1[s], e_rs1v[s]);
                lookup(a2[s], bp, rd[1], al[1], e_rs2[s], e_rs2v[s]);
                if (w[s]) lookup(rd[s], bp, rd[1], al[1], e_old[s], e_oldv[s]);
                else begin
                    e_old[s] = 0; e_oldv[s] = 0;
                end
            end
            for (int s = 1; s <= 2; s++)
                if (w[s]) begin
                    m_sv[rd[s]] = 1'b1; m_st[rd[s]] = al[s];
                end
        end
    endtask

    task automatic check_outputs();
        for (int s = 1; s <= 2; s++) begin
            check($sformatf("rn_valid_%0d", s), 32'(o_v[s]), 32'(e_v[s]));
            if (e_v[s]) begin
                check($sformatf("rn_rs1_%0d", s),  32'(o_rs1[s]),  32'(e_rs1[s]));
                check($sformatf("rn_rs1v_%0d", s), 32'(o_rs1v[s]), 32'(e_rs1v[s]));
                check($sformatf("rn_rs2_%0d", s),  32'(o_rs2[s]),  32'(e_rs2[s]));
                check($sformatf("rn_rs2v_%0d", s), 32'(o_rs2v[s]), 32'(e_rs2v[s]));
                check($sformatf("rn_rd_%0d", s),   32'(o_rd[s]),   32'(e_rd[s]));
                check($sformatf("rn_wr_%0d", s),   32'(o_wr[s]),   32'(e_wr[s]));
                check($sformatf("rn_old_%0d", s),  32'(o_old[s]),  32'(e_old[s]));
                check($sformatf("rn_oldv_%0d", s), 32'(o_oldv[s]), 32'(e_oldv[s]));
            end
        end
    endtask

    task automatic check_comb();
        check("stall_rn", 32'(stall_rn), 32'(!(!prmiss && !stall_DP && allocatable)));
        for (int s = 1; s <= 2; s++)
            check($sformatf("alloc_inv_%0d", s), 32'(o_inv[s]), 32'(!(v[s] && wr[s] && rd[s] != 0)));
    endtask

    // Inputs are already set; check comb paths, take one edge, then check registered outputs.
    task automatic cycle();
        #1 check_comb();
        @(posedge clk);
        model_edge();
        #1 check_outputs();
    endtask

    task automatic set_slot(input int s, input logic vv, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] d, input logic ww, input logic [5:0] t);
        v[s] = vv; a1[s] = r1; a2[s] = r2; rd[s] = d; wr[s] = ww; al[s] = t;
    endtask

    task automatic clear_inputs();
        prmiss = 0; stall_DP = 0; allocatable = 1;
        for (int s = 1; s <= 2; s++) begin
            set_slot(s, 0, 0, 0, 0, 0, 0);
            alv[s] = 1; cv[s] = 0; crd[s] = 0; cp[s] = 0;
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs();
        reset = 1'b1;

        // r5 <- r1 + r2 on an empty map
        set_slot(1, 1, 1, 2, 5, 1, 3);
        cycle();
        check("t1_rd", 32'(o_rd[1]), 32'd3);
        check("t1_rs1v", 32'(o_rs1v[1]), 32'd0);
        check("t1_oldv", 32'(o_oldv[1]), 32'd0);

        // r4 <- r5 ; r6 <- r4 : slot 2 bypasses slot 1's fresh tag
        set_slot(1, 1, 5, 0, 4, 1, 7);
        set_slot(2, 1, 4, 0, 6, 1, 8);
        cycle();
        check("t2_rs1_1", 32'(o_rs1[1]), 32'd3);
        check("t2_rs1_2", 32'(o_rs1[2]), 32'd7);
        check("t2_rs1v_2", 32'(o_rs1v[2]), 32'd1);
        check("t2_rd_2", 32'(o_rd[2]), 32'd8);

        // both write r9: slot 2's old is slot 1's new tag, slot 2 owns the map entry
        set_slot(1, 1, 0, 0, 9, 1, 10);
        set_slot(2, 1, 0, 0, 9, 1, 11);
        cycle();
        check("t3_old_2", 32'(o_old[2]), 32'd10);
        check("t3_oldv_2", 32'(o_oldv[2]), 32'd1);
        set_slot(1, 1, 9, 0, 0, 0, 0);
        set_slot(2, 0, 0, 0, 0, 0, 0);
        cycle();
        check("t3_r9", 32'(o_rs1[1]), 32'd11);

        // back-end stall with changing decode inputs
        stall_DP = 1;
        for (int i = 0; i < 3; i++) begin
            set_slot(1, 1, 5'(i + 1), 0, 9, 1, 6'(20 + i));
            set_slot(2, 1, 9, 0, 9, 1, 6'(30 + i));
            cycle();
            check("stall_hold", 32'(o_rs1[1]), 32'd11);
        end
        stall_DP = 0;
        set_slot(1, 1, 9, 0, 0, 0, 0);
        set_slot(2, 0, 0, 0, 0, 0, 0);
        cycle();
        check("stall_map", 32'(o_rs1[1]), 32'd11);

        // freelist empty, then released
        allocatable = 0;
        set_slot(1, 1, 4, 6, 12, 1, 40);
        cycle();
        cycle();
        allocatable = 1;
        cycle();
        check("alloc_rel", 32'(o_rd[1]), 32'd40);

        // commit r3->12, speculative r3->14, then prmiss with same-cycle commit r7->15
        cv[1] = 1; crd[1] = 3; cp[1] = 12;
        set_slot(1, 1, 0, 0, 3, 1, 14);
        cycle();
        cv[1] = 0;
        set_slot(1, 1, 3, 0, 0, 0, 0);
        cycle();
        check("spec_r3", 32'(o_rs1[1]), 32'd14);
        prmiss = 1; cv[1] = 1; crd[1] = 7; cp[1] = 15;
        set_slot(1, 1, 1, 1, 2, 1, 50);
        set_slot(2, 1, 1, 1, 2, 1, 51);
        cycle();
        check("pm_valid_1", 32'(o_v[1]), 32'd0);
        check("pm_valid_2", 32'(o_v[2]), 32'd0);
        prmiss = 0; cv[1] = 0;
        set_slot(1, 1, 3, 7, 0, 0, 0);
        set_slot(2, 1, 9, 2, 0, 0, 0);
        cycle();
        check("pm_r3", 32'(o_rs1[1]), 32'd12);
        check("pm_r7", 32'(o_rs2[1]), 32'd15);
        check("pm_r9v", 32'(o_rs1v[2]), 32'd0);

        // async reset asserted mid-stall, checked before any clock edge
        stall_DP = 1;
        #3 reset = 1'b0;
        model_reset();
        #1 check_outputs();
        check("rst_valid_1", 32'(o_v[1]), 32'd0);
        check("rst_rs1_1", 32'(o_rs1[1]), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        stall_DP = 0;
        set_slot(1, 1, 9, 3, 0, 0, 0);
        set_slot(2, 1, 7, 4, 0, 0, 0);
        cycle();
        check("rst_map_r9", 32'(o_rs1v[1]), 32'd0);
        check("rst_map_r7", 32'(o_rs1v[2]), 32'd0);

        // random traffic over a small register window to force collisions
        for (int n = 0; n < 600; n++) begin
            prmiss      = ($urandom_range(0, 15) == 0);
            stall_DP    = ($urandom_range(0, 5) == 0);
            allocatable = ($urandom_range(0, 5) != 0);
            for (int s = 1; s <= 2; s++) begin
                set_slot(s, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 1'($urandom), 6'($urandom));
                cv[s]  = 1'($urandom);
                crd[s] = 5'($urandom_range(0, 7));
                cp[s]  = 6'($urandom);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
